// File: rtl/flit_bus_arbiter_pkg.sv
// ============================================================================
// Module : flit_bus_arbiter_pkg
// Brief  : Shared types and helpers for the flit bus arbiter slice.
//          Width macros normally come from const.v; fallbacks below keep the
//          slice self-contained when const.v is not part of the build.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef A_WIDTH
`define A_WIDTH 8
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif

package flit_bus_arbiter_pkg;

  // Saturation value of the optional statistics counters.
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Contents of the shared bus output register.
  typedef struct packed {
    logic                   valid;
    logic [`FLIT_WIDTH-1:0] flit;
    logic [`A_WIDTH-1:0]    nexthop;
  } bus_reg_t;

  // Number of bits needed to represent the value 'depth' (CLogB2(7)=3).
  function automatic int CLogB2(input int depth);
    int r;
    int d;
    r = 0;
    d = depth;
    while (d > 0) begin
      r = r + 1;
      d = d >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/flit_bus_arbiter_rr_select.sv
// ============================================================================
// Module : rr_select
// Brief  : Purely combinational round-robin picker. Searches request[] from
//          ptr+1 upward, wrapping modulo NNODES, ending at ptr itself.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_select
  import flit_bus_arbiter_pkg::*;
#(
  parameter int NNODES     = 8,
  parameter int LOG_NNODES = CLogB2(NNODES - 1)
) (
  input  logic [NNODES-1:0]     request,
  input  logic [LOG_NNODES-1:0] ptr,
  output logic [NNODES-1:0]     grant,
  output logic [LOG_NNODES-1:0] index
);

  // One extra bit so ptr+i never overflows before the modulo wrap.
  typedef logic [LOG_NNODES:0] sum_t;

  sum_t w_pos;
  logic w_found;

  // First requester after ptr wins; ptr itself is checked last.
  always_comb begin
    grant   = '0;
    index   = '0;
    w_found = 1'b0;
    w_pos   = '0;
    for (int i = 1; i <= NNODES; i++) begin
      w_pos = {1'b0, ptr} + sum_t'(i);
      if (w_pos >= sum_t'(NNODES)) begin
        w_pos = w_pos - sum_t'(NNODES);
      end
      if (!w_found && request[w_pos[LOG_NNODES-1:0]]) begin
        w_found                        = 1'b1;
        index                          = w_pos[LOG_NNODES-1:0];
        grant[w_pos[LOG_NNODES-1:0]]   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/flit_bus_arbiter.sv
// ============================================================================
// Module : flit_bus_arbiter
// Brief  : Round-robin arbiter moving one flit per cycle from NNODES node
//          output queues onto a single shared bus register.
//          Optional macro FLIT_BUS_ARB_STATS_EN adds saturating grant and
//          stall counters (grant_count / stall_count outputs).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module flit_bus_arbiter
  import flit_bus_arbiter_pkg::*;
#(
  parameter int NNODES     = 8,
  parameter int LOG_NNODES = CLogB2(NNODES - 1)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NNODES-1:0]             in_valid,
  input  logic [NNODES*`FLIT_WIDTH-1:0] in_flit,
  input  logic [NNODES*`A_WIDTH-1:0]    in_nexthop,
  output logic [NNODES-1:0]             in_dequeue,
  output logic                          out_valid,
  output logic [`FLIT_WIDTH-1:0]        out_flit,
  output logic [`A_WIDTH-1:0]           out_nexthop,
  input  logic                          out_ack,
  output logic                          error
`ifdef FLIT_BUS_ARB_STATS_EN
  ,
  output logic [15:0]                   grant_count,
  output logic [15:0]                   stall_count
`endif
);

  bus_reg_t                r_bus;
  logic [LOG_NNODES-1:0]   r_ptr;
  logic                    r_error;

  logic [NNODES-1:0]       w_onehot;
  logic [LOG_NNODES-1:0]   w_idx;
  logic                    w_free;
  logic                    w_grant_ok;
  logic                    w_grant;
  logic [`FLIT_WIDTH-1:0]  w_sel_flit;
  logic [`A_WIDTH-1:0]     w_sel_nexthop;

  rr_select #(
    .NNODES     (NNODES),
    .LOG_NNODES (LOG_NNODES)
  ) u_rr_select (
    .request (in_valid),
    .ptr     (r_ptr),
    .grant   (w_onehot),
    .index   (w_idx)
  );

  // The register can take a new flit when empty or being drained this cycle.
  assign w_free     = ~r_bus.valid | out_ack;
  assign w_grant_ok = enable & w_free;
  assign w_grant    = w_grant_ok & (|in_valid);

  // Reset only masks the outward dequeue; the flops are already held by it.
  assign in_dequeue = (w_grant_ok && !reset) ? w_onehot : '0;

  assign out_valid   = r_bus.valid;
  assign out_flit    = r_bus.flit;
  assign out_nexthop = r_bus.nexthop;
  assign error       = r_error;

  // Mux the winning node's flit and nexthop out of the packed input buses.
  always_comb begin
    w_sel_flit    = '0;
    w_sel_nexthop = '0;
    for (int k = 0; k < NNODES; k++) begin
      if (w_idx == LOG_NNODES'(k)) begin
        w_sel_flit    = in_flit[k*`FLIT_WIDTH +: `FLIT_WIDTH];
        w_sel_nexthop = in_nexthop[k*`A_WIDTH +: `A_WIDTH];
      end
    end
  end

  // Grant pointer, bus register and sticky protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr   <= LOG_NNODES'(NNODES - 1);
      r_bus   <= '0;
      r_error <= 1'b0;
    end else begin
      if (w_grant) begin
        r_ptr         <= w_idx;
        r_bus.valid   <= 1'b1;
        r_bus.flit    <= w_sel_flit;
        r_bus.nexthop <= w_sel_nexthop;
      end else if (out_ack) begin
        r_bus.valid   <= 1'b0;
      end
      if (out_ack && !r_bus.valid) begin
        r_error <= 1'b1;
      end
    end
  end

`ifdef FLIT_BUS_ARB_STATS_EN
  logic [15:0] r_grant_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating counts of grants and of cycles the bus flit waits for an ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_grant_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant && r_grant_cnt != STAT_MAX) begin
        r_grant_cnt <= r_grant_cnt + 16'd1;
      end
      if (r_bus.valid && !out_ack && r_stall_cnt != STAT_MAX) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign grant_count = r_grant_cnt;
  assign stall_count = r_stall_cnt;
`else
  // Statistics disabled: no counters are built.
`endif

endmodule

`default_nettype wire

// File: tb/tb_flit_bus_arbiter.sv
// ============================================================================
// Module : tb_flit_bus_arbiter
// Brief  : Directed self-checking bench for flit_bus_arbiter (NNODES=8).
//          Optional macro FLIT_BUS_ARB_STATS_EN enables counter checks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef A_WIDTH
`define A_WIDTH 8
`endif

module tb_flit_bus_arbiter;

  localparam int N  = 8;
  localparam int FW = `FLIT_WIDTH;
  localparam int AW = `A_WIDTH;

  logic              clock;
  logic              reset;
  logic              enable;
  logic [N-1:0]      in_valid;
  logic [N*FW-1:0]   in_flit;
  logic [N*AW-1:0]   in_nexthop;
  logic [N-1:0]      in_dequeue;
  logic              out_valid;
  logic [FW-1:0]     out_flit;
  logic [AW-1:0]     out_nexthop;
  logic              out_ack;
  logic              error;
`ifdef FLIT_BUS_ARB_STATS_EN
  logic [15:0]       grant_count;
  logic [15:0]       stall_count;
`endif

  logic [FW-1:0]     flits [N];
  int                errors;
  int                checks;

  flit_bus_arbiter #(.NNODES(N)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_flit     (in_flit),
    .in_nexthop  (in_nexthop),
    .in_dequeue  (in_dequeue),
    .out_valid   (out_valid),
    .out_flit    (out_flit),
    .out_nexthop (out_nexthop),
    .out_ack     (out_ack),
    .error       (error)
`ifdef FLIT_BUS_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Node k carries flits[k] and nexthop 0x40+k.
  always_comb begin
    in_flit    = '0;
    in_nexthop = '0;
    for (int k = 0; k < N; k++) begin
      in_flit[k*FW +: FW]    = flits[k];
      in_nexthop[k*AW +: AW] = AW'(8'h40 + k);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    for (int k = 0; k < N; k++) flits[k] = FW'(32'hA000_0000 | k);
    flits[3] = FW'(32'h1234);
    reset    = 1'b1;
    enable   = 1'b1;
    in_valid = 8'hFF;
    out_ack  = 1'b0;

    // Reset state, with requests pending
    tick(); tick();
    chk("rst_valid",   32'(out_valid), 32'h0);
    chk("rst_flit",    32'(out_flit), 32'h0);
    chk("rst_nexthop", 32'(out_nexthop), 32'h0);
    chk("rst_error",   32'(error), 32'h0);
    chk("rst_dequeue", 32'(in_dequeue), 32'h0);
`ifdef FLIT_BUS_ARB_STATS_EN
    chk("rst_gcnt", 32'(grant_count), 32'h0);
    chk("rst_scnt", 32'(stall_count), 32'h0);
`endif
    in_valid = 8'h00;
    reset    = 1'b0;
    tick();

    // All nodes requesting: grants 0..7,0 one per cycle
    in_valid = 8'hFF;
    #1;
    chk("rr_first_deq", 32'(in_dequeue), 32'h01);
    tick();
    out_ack = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk("rr_valid", 32'(out_valid), 32'h1);
      chk("rr_flit",  32'(out_flit), 32'(flits[k-1]));
      chk("rr_deq",   32'(in_dequeue), 32'(8'h01 << (k % 8)));
      tick();
    end
    chk("rr_wrap_flit", 32'(out_flit), 32'(flits[0]));
    in_valid = 8'h00;
    #1;
    chk("rr_drain_deq", 32'(in_dequeue), 32'h0);
    tick();
    out_ack = 1'b0;
    #1;
    chk("rr_empty", 32'(out_valid), 32'h0);

    // Single requester node 3
    in_valid = 8'h08;
    #1;
    chk("n3_deq", 32'(in_dequeue), 32'h08);
    tick();
    in_valid = 8'h00;
    #1;
    chk("n3_valid",   32'(out_valid), 32'h1);
    chk("n3_flit",    32'(out_flit), 32'h1234);
    chk("n3_nexthop", 32'(out_nexthop), 32'h43);
    chk("n3_deq_off", 32'(in_dequeue), 32'h0);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("n3_retired", 32'(out_valid), 32'h0);

    // Node 5 held four cycles without ack, then next valid after 5 is 7
    in_valid = 8'h20;
    #1;
    chk("n5_deq", 32'(in_dequeue), 32'h20);
    tick();
    in_valid = 8'hA8;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("hold_deq",  32'(in_dequeue), 32'h0);
      chk("hold_flit", 32'(out_flit), 32'(flits[5]));
      chk("hold_nh",   32'(out_nexthop), 32'h45);
      tick();
    end
    out_ack = 1'b1;
    #1;
    chk("after5_deq", 32'(in_dequeue), 32'h80);
    tick();
    out_ack = 1'b0;
    #1;
    chk("n7_flit", 32'(out_flit), 32'(flits[7]));
    chk("n7_deq",  32'(in_dequeue), 32'h0);

    // enable low: ack still retires, no grants, ptr kept at 7
    enable   = 1'b0;
    in_valid = 8'h28;
    out_ack  = 1'b1;
    #1;
    chk("dis_deq_ack", 32'(in_dequeue), 32'h0);
    tick();
    out_ack = 1'b0;
    #1;
    chk("dis_retired", 32'(out_valid), 32'h0);
    chk("dis_deq",     32'(in_dequeue), 32'h0);
    tick();
    chk("dis_deq2", 32'(in_dequeue), 32'h0);
    enable = 1'b1;
    #1;
    chk("en_resume_deq", 32'(in_dequeue), 32'h08);
    tick();
    in_valid = 8'h00;
    #1;
    chk("en_resume_flit", 32'(out_flit), 32'h1234);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("pre_err_valid", 32'(out_valid), 32'h0);
    chk("pre_err",       32'(error), 32'h0);

    // Ack with empty bus sets sticky error
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("err_set", 32'(error), 32'h1);
    tick(); tick();
    chk("err_sticky", 32'(error), 32'h1);

    // Reset mid-transfer, then node 0 wins first
    in_valid = 8'hFF;
    #1;
    chk("pre_rst_deq", 32'(in_dequeue), 32'h10);
    tick();
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_flit",  32'(out_flit), 32'h0);
    chk("mid_rst_nh",    32'(out_nexthop), 32'h0);
    chk("mid_rst_error", 32'(error), 32'h0);
    chk("mid_rst_deq",   32'(in_dequeue), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_deq", 32'(in_dequeue), 32'h01);
`ifdef FLIT_BUS_ARB_STATS_EN
    chk("post_rst_gcnt", 32'(grant_count), 32'h0);
`endif
    tick();
    chk("post_rst_flit", 32'(out_flit), 32'(flits[0]));
    chk("post_rst_nh",   32'(out_nexthop), 32'h40);
`ifdef FLIT_BUS_ARB_STATS_EN
    chk("gcnt_1", 32'(grant_count), 32'h1);
    chk("scnt_0", 32'(stall_count), 32'h0);
    tick();
    chk("scnt_1", 32'(stall_count), 32'h1);
    chk("gcnt_1b", 32'(grant_count), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
